// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  // Prefetch buffer depth; also caps requests in flight plus buffered entries.
  localparam int FIFO_DEPTH = 2;
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W      = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

  // Saturating 16-bit increment used by the optional performance counters.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit bus: program-memory request/response plus the decode handshake
// and control inputs. master = fetch unit, slave = memory/decode environment.
interface fetch_unit_if #(
  parameter int PC_W   = 13,
  parameter int INST_W = 8
);
  logic              mem_req;
  logic [PC_W-1:0]   mem_addr;
  logic              mem_rvalid;
  logic [INST_W-1:0] mem_rdata;
  logic [INST_W-1:0] inst_reg;
  logic              inst_valid;
  logic              inst_ready;
  logic [PC_W-1:0]   inst_pc;
  logic              redirect;
  logic [PC_W-1:0]   redirect_pc;
  logic              halt;

  modport master (
    output mem_req, mem_addr, inst_reg, inst_valid, inst_pc,
    input  mem_rvalid, mem_rdata, inst_ready, redirect, redirect_pc, halt
  );

  modport slave (
    input  mem_req, mem_addr, inst_reg, inst_valid, inst_pc,
    output mem_rvalid, mem_rdata, inst_ready, redirect, redirect_pc, halt
  );
endinterface

// File: rtl/fetch_fifo.sv
// Small prefetch FIFO of {inst, pc}. Head is presented combinationally.
// Flush empties it regardless of push/pop in the same cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int PC_W   = 13,
  parameter int INST_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              push,
  input  logic [INST_W-1:0] push_inst,
  input  logic [PC_W-1:0]   push_pc,
  input  logic              pop,
  output logic [INST_W-1:0] head_inst,
  output logic [PC_W-1:0]   head_pc,
  output logic [CNT_W-1:0]  count
);

  logic [FIFO_DEPTH-1:0][INST_W-1:0] inst_mem_q, inst_mem_d;
  logic [FIFO_DEPTH-1:0][PC_W-1:0]   pc_mem_q, pc_mem_d;
  logic [PTR_W-1:0]                  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]                  count_q, count_d;
  logic                              do_push, do_pop;

  // Next-state: push/pop bookkeeping, flush wins over both.
  always_comb begin
    inst_mem_d = inst_mem_q;
    pc_mem_d   = pc_mem_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    do_pop     = pop && (count_q != '0);
    do_push    = push && ((count_q != CNT_W'(FIFO_DEPTH)) || do_pop);
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        inst_mem_d[wr_ptr_q] = push_inst;
        pc_mem_d[wr_ptr_q]   = push_pc;
        wr_ptr_d             = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage and pointer registers; storage zeroed so the head reads 0 in reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      inst_mem_q <= '0;
      pc_mem_q   <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      inst_mem_q <= inst_mem_d;
      pc_mem_q   <= pc_mem_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  assign head_inst = inst_mem_q[rd_ptr_q];
  assign head_pc   = pc_mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues in-order reads to program memory, buffers
// responses in a 2-entry prefetch FIFO and presents them to decode.
// Optional feature macro: FETCH_UNIT_PERF_EN adds fetch/stall counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              PC_W     = 13,
  parameter int              INST_W   = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus
`ifdef FETCH_UNIT_PERF_EN
  ,
  output logic [15:0]  fetch_count,
  output logic [15:0]  stall_count
`endif
);

  fetch_state_e      state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;       // next request address
  logic [PC_W-1:0]   rpc_q, rpc_d;     // address of next kept response
  logic [CNT_W-1:0]  outst_q, outst_d; // requests awaiting a response
  logic [CNT_W-1:0]  drop_q, drop_d;   // subset of outstanding to discard
  logic [CNT_W:0]    inflight;
  logic [CNT_W-1:0]  fifo_count;
  logic [INST_W-1:0] head_inst;
  logic [PC_W-1:0]   head_pc;
  logic              issue, rsp, push, pop, inst_valid;

  // Request issue, response accounting and redirect flush.
  always_comb begin
    inflight = {1'b0, fifo_count} + {1'b0, outst_q};
    rsp      = bus.mem_rvalid && (outst_q != '0);
    issue    = (state_q == FETCH) && !bus.halt && !bus.redirect &&
               (inflight < (CNT_W+1)'(FIFO_DEPTH));
    pop      = inst_valid && bus.inst_ready;
    push     = rsp && (drop_q == '0) && !bus.redirect;
    outst_d  = outst_q + CNT_W'(issue) - CNT_W'(rsp);
    drop_d   = drop_q;
    pc_d     = pc_q;
    rpc_d    = rpc_q;
    if (bus.redirect) begin
      // Everything still in flight is stale, including a response landing now.
      drop_d = outst_q - CNT_W'(rsp);
      pc_d   = bus.redirect_pc;
      rpc_d  = bus.redirect_pc;
    end else begin
      if (rsp && (drop_q != '0)) drop_d = drop_q - CNT_W'(1);
      if (issue) pc_d = pc_q + PC_W'(1);
      if (push) rpc_d = rpc_q + PC_W'(1);
    end
  end

  // FSM next state: redirect holds the current run state for that cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = FETCH;
      FETCH:   if (!bus.redirect && bus.halt) state_d = HALTED;
      HALTED:  if (!bus.redirect && !bus.halt) state_d = FETCH;
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset abandons anything in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      rpc_q   <= RESET_PC;
      outst_q <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      rpc_q   <= rpc_d;
      outst_q <= outst_d;
      drop_q  <= drop_d;
    end
  end

  fetch_fifo #(.PC_W(PC_W), .INST_W(INST_W)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (bus.redirect),
    .push      (push),
    .push_inst (bus.mem_rdata),
    .push_pc   (rpc_q),
    .pop       (pop),
    .head_inst (head_inst),
    .head_pc   (head_pc),
    .count     (fifo_count)
  );

  assign inst_valid     = (fifo_count != '0);
  assign bus.mem_req    = issue;
  assign bus.mem_addr   = pc_q;
  assign bus.inst_valid = inst_valid;
  assign bus.inst_reg   = head_inst;
  assign bus.inst_pc    = head_pc;

`ifdef FETCH_UNIT_PERF_EN
  logic [15:0] fetch_cnt_q, fetch_cnt_d, stall_cnt_q, stall_cnt_d;

  // Saturating counters: decode transfers, and cycles decode waits on fetch.
  always_comb begin
    fetch_cnt_d = pop ? sat_inc16(fetch_cnt_q) : fetch_cnt_q;
    stall_cnt_d = (bus.inst_ready && !inst_valid) ? sat_inc16(stall_cnt_q) : stall_cnt_q;
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fetch_count = fetch_cnt_q;
  assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit. dut0 starts at PC 0, dut1 starts at
// 1FFE to exercise wrap and halt. Memory is a latency-programmable pipeline.
module tb_fetch_unit;
  localparam int PC_W = 13, INST_W = 8;

  typedef struct { logic [7:0] rdata_in; logic [12:0] exp_pc; logic [7:0] exp_inst; } vec_t;
  typedef struct { logic [7:0] inst; logic [12:0] pc; } xfer_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst_n, rdy, hlt, redir, rv;
  logic [1:0][12:0] rpc;
  logic [1:0][7:0]  rd;
  logic [1:0]       req_w, ivld_w;
  logic [1:0][12:0] addr_w, ipc_w;
  logic [1:0][7:0]  inst_w;

  fetch_unit_if #(.PC_W(PC_W), .INST_W(INST_W)) if0 ();
  fetch_unit_if #(.PC_W(PC_W), .INST_W(INST_W)) if1 ();

  assign if0.mem_rvalid  = rv[0];    assign if1.mem_rvalid  = rv[1];
  assign if0.mem_rdata   = rd[0];    assign if1.mem_rdata   = rd[1];
  assign if0.inst_ready  = rdy[0];   assign if1.inst_ready  = rdy[1];
  assign if0.redirect    = redir[0]; assign if1.redirect    = redir[1];
  assign if0.redirect_pc = rpc[0];   assign if1.redirect_pc = rpc[1];
  assign if0.halt        = hlt[0];   assign if1.halt        = hlt[1];
  assign req_w[0]  = if0.mem_req;    assign req_w[1]  = if1.mem_req;
  assign addr_w[0] = if0.mem_addr;   assign addr_w[1] = if1.mem_addr;
  assign ivld_w[0] = if0.inst_valid; assign ivld_w[1] = if1.inst_valid;
  assign ipc_w[0]  = if0.inst_pc;    assign ipc_w[1]  = if1.inst_pc;
  assign inst_w[0] = if0.inst_reg;   assign inst_w[1] = if1.inst_reg;

`ifdef FETCH_UNIT_PERF_EN
  logic [15:0] fc0, sc0, fc1, sc1;
`endif

  fetch_unit #(.PC_W(PC_W), .INST_W(INST_W), .RESET_PC(13'h0000)) dut0 (
    .clk(clk), .reset(rst_n[0]), .bus(if0)
`ifdef FETCH_UNIT_PERF_EN
    , .fetch_count(fc0), .stall_count(sc0)
`endif
  );

  fetch_unit #(.PC_W(PC_W), .INST_W(INST_W), .RESET_PC(13'h1FFE)) dut1 (
    .clk(clk), .reset(rst_n[1]), .bus(if1)
`ifdef FETCH_UNIT_PERF_EN
    , .fetch_count(fc1), .stall_count(sc1)
`endif
  );

  // Memory model and observation state.
  logic        pv [2][4];
  logic [12:0] pa [2][4];
  int          lat [2];
  int          nreq [2];
  int          first_req [2], first_rv [2], first_iv [2];
  int          cyc;
  logic [7:0]  mem_img [3];
  logic [1:0]       lreq, lvld;
  logic [1:0][7:0]  linst;
  logic [1:0][12:0] lipc;
  xfer_t       rx0[$], rx1[$];
  logic [12:0] rlog1[$], rlog0[$];
  int          n_chk, n_pass;

  function automatic logic [7:0] mem_data(input logic [12:0] a);
    if (a < 13'd3) return mem_img[a[1:0]];
    return a[7:0] ^ 8'hA5;
  endfunction

  function automatic xfer_t rx0_at(input int i);
    xfer_t x;
    x.inst = 'x; x.pc = 'x;
    if (i < rx0.size()) x = rx0[i];
    return x;
  endfunction

  function automatic logic [12:0] rlog_at(input int d, input int i);
    if (d == 0 && i < rlog0.size()) return rlog0[i];
    if (d == 1 && i < rlog1.size()) return rlog1[i];
    return 'x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  // One clock: drive memory responses, sample outputs mid-cycle, advance.
  task automatic cycle();
    xfer_t x;
    for (int d = 0; d < 2; d++) begin
      rv[d] = pv[d][lat[d]];
      rd[d] = mem_data(pa[d][lat[d]]);
      if (rv[d] && first_rv[d] < 0) first_rv[d] = cyc;
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      pv[d][0] = (req_w[d] === 1'b1);
      pa[d][0] = addr_w[d];
      lreq[d] = req_w[d]; lvld[d] = ivld_w[d]; linst[d] = inst_w[d]; lipc[d] = ipc_w[d];
      if (pv[d][0]) begin
        nreq[d]++;
        if (first_req[d] < 0) first_req[d] = cyc;
        if (d == 0) rlog0.push_back(addr_w[d]); else rlog1.push_back(addr_w[d]);
      end
      if (ivld_w[d] === 1'b1 && first_iv[d] < 0) first_iv[d] = cyc;
      if (ivld_w[d] === 1'b1 && rdy[d]) begin
        x.inst = inst_w[d]; x.pc = ipc_w[d];
        if (d == 0) rx0.push_back(x); else rx1.push_back(x);
      end
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      for (int k = 3; k > 0; k--) begin pv[d][k] = pv[d][k-1]; pa[d][k] = pa[d][k-1]; end
      pv[d][0] = 1'b0;
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t  tbl [3];
    xfer_t x;
    int rel, base, n0, maxin, unstable, errs, hreq;
    logic got;
    logic [7:0]  hi;
    logic [12:0] hp;

    tbl[0] = '{8'h1D, 13'd0, 8'h1D};
    tbl[1] = '{8'h1F, 13'd1, 8'h1F};
    tbl[2] = '{8'h39, 13'd2, 8'h39};
    for (int i = 0; i < 3; i++) mem_img[i] = tbl[i].rdata_in;
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 4; k++) begin pv[d][k] = 1'b0; pa[d][k] = '0; end
      lat[d] = 1; nreq[d] = 0; first_req[d] = -1; first_rv[d] = -1; first_iv[d] = -1;
    end
    n_chk = 0; n_pass = 0; cyc = 0;
    rst_n = 2'b00; rdy = 2'b11; hlt = 2'b00; redir = 2'b00; rpc = '0; rv = '0; rd = '0;

    // Reset: two cycles low.
    @(negedge clk);
    cycle(); cycle();
    chk("rst_req0", lreq[0], 0);
    chk("rst_valid0", lvld[0], 0);
    chk("rst_inst0", linst[0], 0);
    chk("rst_pc0", lipc[0], 0);
    chk("rst_addr0", addr_w[0], 13'h0000);
    chk("rst_req1", lreq[1], 0);
    chk("rst_addr1", addr_w[1], 13'h1FFE);

    // Release and stream with 1-cycle memory.
    rst_n = 2'b11;
    rel = cyc;
    for (int t = 0; t < 20 && rx0.size() < 3; t++) cycle();
    chk("first_req_cycle", first_req[0], rel + 1);
    chk("first_valid_cycle", first_iv[0], first_rv[0] + 1);
    chk("req_addr_0", rlog_at(0, 0), 13'h0000);
    chk("req_addr_1", rlog_at(0, 1), 13'h0001);
    for (int i = 0; i < 3; i++) begin
      x = rx0_at(i);
      chk($sformatf("stream_inst_%0d", i), x.inst, tbl[i].exp_inst);
      chk($sformatf("stream_pc_%0d", i), x.pc, tbl[i].exp_pc);
    end
    chk("wrap_addr_0", rlog_at(1, 0), 13'h1FFE);
    chk("wrap_addr_1", rlog_at(1, 1), 13'h1FFF);
    chk("wrap_addr_2", rlog_at(1, 2), 13'h0000);

    // Backpressure: decode stalls 10 cycles.
    rdy[0] = 1'b0; maxin = 0; unstable = 0; got = 1'b0; hi = '0; hp = '0;
    for (int t = 0; t < 10; t++) begin
      cycle();
      if (nreq[0] - rx0.size() > maxin) maxin = nreq[0] - rx0.size();
      if (lvld[0]) begin
        if (!got) begin hi = linst[0]; hp = lipc[0]; got = 1'b1; end
        else if (linst[0] !== hi || lipc[0] !== hp) unstable++;
      end
    end
    chk("bp_max_inflight_le2", maxin <= 2, 1);
    chk("bp_inflight_end", nreq[0] - rx0.size(), 2);
    chk("bp_stable", unstable, 0);
    chk("bp_valid_held", lvld[0], 1);

    // Release and drain under halt; every address arrives exactly once, in order.
    rdy[0] = 1'b1; hlt[0] = 1'b1;
    for (int t = 0; t < 8; t++) cycle();
    errs = 0;
    foreach (rx0[i]) if (rx0[i].pc !== 13'(i) || rx0[i].inst !== mem_data(13'(i))) errs++;
    chk("no_loss_order", errs, 0);
    chk("all_delivered", rx0.size(), nreq[0]);

    // Redirect with two stale requests in flight on a 3-cycle memory.
    lat[0] = 3; hlt[0] = 1'b0; base = nreq[0];
    for (int t = 0; t < 10 && nreq[0] - base < 2; t++) cycle();
    chk("rd_two_outstanding", nreq[0] - base, 2);
    redir[0] = 1'b1; rpc[0] = 13'h0040;
    cycle();
    chk("rd_req_blocked", lreq[0], 0);
    redir[0] = 1'b0;
    n0 = rx0.size();
    for (int t = 0; t < 30 && rx0.size() < n0 + 2; t++) cycle();
    x = rx0_at(n0);
    chk("rd_first_pc", x.pc, 13'h0040);
    chk("rd_first_inst", x.inst, 8'hE5);
    x = rx0_at(n0 + 1);
    chk("rd_second_pc", x.pc, 13'h0041);

    // Halt on dut1 with a full FIFO: no requests, buffered entries drain.
    rdy[1] = 1'b0;
    for (int t = 0; t < 5; t++) cycle();
    chk("halt_prefill", lvld[1], 1);
    hlt[1] = 1'b1; rdy[1] = 1'b1; base = rx1.size(); hreq = 0;
    for (int t = 0; t < 6; t++) begin
      cycle();
      if (lreq[1]) hreq++;
    end
    chk("halt_no_req", hreq, 0);
    chk("halt_drained", rx1.size() - base, 2);
    chk("halt_empty", lvld[1], 0);
    hlt[1] = 1'b0; base = nreq[1];
    for (int t = 0; t < 4; t++) cycle();
    chk("halt_resume", nreq[1] > base, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter PC_W, default 13, program-counter/address width.
REQ-002 SHALL have parameter INST_W, default 8, instruction width (matches decode inst_reg).
REQ-003 SHALL have parameter RESET_PC, default 0, first fetch address after reset.
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-low reset.
REQ-006 SHALL have port mem_req  out  1  read request to program memory, accepted every cycle it is high.
REQ-007 SHALL have port mem_addr  out  PC_W  address of current request.
REQ-008 SHALL have port mem_rvalid  in  1  one in-order response per request, latency >=1 cycle.
REQ-009 SHALL have port mem_rdata  in  INST_W  response data, qualified by mem_rvalid.
REQ-010 SHALL have port inst_reg  out  INST_W  instruction presented to decode.
REQ-011 SHALL have port inst_valid  out  1  inst_reg/inst_pc valid.
REQ-012 SHALL have port inst_ready  in  1  decode accepts; transfer when inst_valid & inst_ready.
REQ-013 SHALL have port inst_pc  out  PC_W  address of presented instruction.
REQ-014 SHALL have port redirect  in  1  branch/jump: flush and refetch from redirect_pc.
REQ-015 SHALL have port redirect_pc  in  PC_W  new fetch address.
REQ-016 SHALL have port halt  in  1  stop issuing new requests.

Function
REQ-017 SHALL hold a 2-entry prefetch FIFO of {inst, pc}; head drives inst_reg/inst_pc, inst_valid = FIFO non-empty.
REQ-018 SHALL issue mem_req only when state FETCH, halt low, redirect low and fifo_count + outstanding < 2.
REQ-019 SHALL increment fetch pc by 1 per issued request, wrapping 2^PC_W-1 -> 0.
REQ-020 SHALL push each non-dropped response into FIFO on mem_rvalid; push and pop in same cycle SHALL leave count unchanged.
REQ-021 SHALL ignore mem_rvalid when outstanding = 0.
REQ-022 SHALL, on redirect, in the same edge: clear FIFO, set drop count = outstanding (including any response arriving that cycle), set pc = redirect_pc; inst_valid SHALL be low the following cycle.
REQ-023 SHALL discard the next drop-count responses, then resume pushing; new requests MAY issue while drops pending.
REQ-024 SHALL give redirect priority over a simultaneous pop, push or halt.
REQ-025 SHALL implement states IDLE (after reset, one cycle) -> FETCH; FETCH -> HALTED when halt; HALTED -> FETCH when halt low; redirect in HALTED updates pc and flushes but stays HALTED.
REQ-026 SHALL, in HALTED, still accept in-flight responses and present/pop FIFO contents.
REQ-027 SHALL hold inst_reg/inst_pc stable while inst_valid & !inst_ready.
REQ-028 SHALL achieve first mem_req one cycle after reset release, first inst_valid the cycle after first mem_rvalid.

Reset
REQ-029 SHALL, while reset low: mem_req=0, mem_addr=RESET_PC, inst_valid=0, inst_reg=0, inst_pc=0, FIFO empty, outstanding=0, drop=0, state IDLE, pc=RESET_PC; reset mid-operation SHALL abandon all in-flight requests.

Configuration
REQ-030 SHALL, with FETCH_UNIT_PERF_EN defined, add output fetch_count (16 bits, saturating) counting inst transfers and output stall_count (16 bits, saturating) counting cycles inst_ready & !inst_valid, both cleared by reset.
REQ-031 SHALL, without FETCH_UNIT_PERF_EN, omit those ports and counters entirely with no other behavioural change.

Structure
REQ-032 SHALL place state enum (IDLE, FETCH, HALTED) and FIFO depth constant in shared package fetch_pkg.
REQ-033 SHALL implement the prefetch FIFO as sub-module fetch_fifo.

Verification
REQ-034 Bench SHALL check reset: reset low 2 cycles -> mem_req=0, inst_valid=0; release -> mem_addr=0 then 1 on successive requests.
REQ-035 Bench SHALL check stream: 1-cycle memory returning 8'h1D,8'h1F,8'h39, inst_ready=1 -> inst_reg 1D,1F,39 with inst_pc 0,1,2 in order.
REQ-036 Bench SHALL check backpressure: inst_ready=0 10 cycles -> at most 2 requests outstanding+buffered, inst_reg stable, no data lost on release.
REQ-037 Bench SHALL check redirect: 3-cycle latency memory, redirect_pc=8'h40 with 2 outstanding -> both stale responses dropped, next inst_pc=8'h40.
REQ-038 Bench SHALL check halt and wrap: RESET_PC=2^PC_W-2 -> addresses 1FFE,1FFF,0000; halt high -> mem_req=0 while buffered instructions still drain.
